// File: rtl/rxshift_deframer.sv
// rxshift_deframer: USRT receive front end.
// Detects the start bit, shifts in 8 data bits LSB first, an optional parity
// bit and STOP_BITS stop bits, then presents {stop,parity,data,start} with a
// one-cycle enable one edge after the final stop bit is sampled.
// Optional macro RX_SYNC_EN: routes i_Rx through a 2-flop synchronizer.
module rxshift_deframer #(
  parameter int STOP_BITS = 1
) (
  input  logic        i_Pclk,
  input  logic        i_Rst_n,
  input  logic        i_Rx,
  input  logic [1:0]  i_Parity,
  output logic [10:0] o_Data,
  output logic        o_Enable,
  output logic        o_FrameErr,
  output logic        o_Busy
);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  state_t     state, state_n;
  logic       rx;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic [1:0] par_mode;
  logic       has_par;
  logic [7:0] shift;
  logic       par_bit;
  logic       frame_done, frame_bad;
  logic       done_pend, err_pend;

`ifdef RX_SYNC_EN
  logic [1:0] sync;

  // Two-flop synchronizer, reset to the idle line level
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) sync <= '1;
    else          sync <= {sync[0], i_Rx};
  end

  assign rx = sync[1];
`else
  assign rx = i_Rx;
`endif

  assign has_par = par_mode[0] ^ par_mode[1];
  assign o_Busy  = (state != IDLE);

  // State register
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state decode and frame completion / framing error strobes
  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:      if (!rx) state_n = DATA;
      DATA:      if (bit_cnt == 3'd7) state_n = has_par ? PARITY : STOP;
      PARITY:    state_n = STOP;
      STOP: begin
        if (!rx) begin
          frame_bad = 1'b1;
          state_n   = WAIT_IDLE;
        end else if (stop_cnt == LAST_STOP) begin
          frame_done = 1'b1;
          state_n    = IDLE;
        end
      end
      WAIT_IDLE: if (rx) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Bit/stop counters, parity mode latch and shift register
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_mode <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx) begin
            bit_cnt  <= '0;
            par_mode <= i_Parity;
            par_bit  <= 1'b0;
          end
        end
        DATA: begin
          shift[bit_cnt] <= rx;
          if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
          stop_cnt <= 1'b0;
        end
        PARITY: begin
          par_bit  <= rx;
          stop_cnt <= 1'b0;
        end
        STOP: begin
          if (rx && (stop_cnt != LAST_STOP)) stop_cnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output frame register and delayed strobes; pulses trail the final stop edge by one cycle
  always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Data     <= '0;
      done_pend  <= 1'b0;
      err_pend   <= 1'b0;
      o_Enable   <= 1'b0;
      o_FrameErr <= 1'b0;
    end else begin
      if (frame_done) o_Data <= {1'b1, par_bit, shift, 1'b0};
      done_pend  <= frame_done;
      err_pend   <= frame_bad;
      o_Enable   <= done_pend;
      o_FrameErr <= err_pend;
    end
  end

endmodule

// File: tb/tb_rxshift_deframer.sv
// Bench for rxshift_deframer: directed line frames, a positional frame model
// for a STOP_BITS=1 and a STOP_BITS=2 instance, per-cycle compare, and
// literal expectations for the known frames.
module tb_rxshift_deframer;

`ifdef RX_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [1:0]  par = 2'b00;

  logic [10:0] data1, data2;
  logic        en1, fe1, busy1, en2, fe2, busy2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int          en_cyc[$];
  logic [10:0] en_data[$];
  int          n_fe1 = 0;
  int          n_en2 = 0;
  int          en2_last = 0;

  rxshift_deframer #(.STOP_BITS(1)) u_dut1 (
    .i_Pclk(clk), .i_Rst_n(rst_n), .i_Rx(rx), .i_Parity(par),
    .o_Data(data1), .o_Enable(en1), .o_FrameErr(fe1), .o_Busy(busy1)
  );

  rxshift_deframer #(.STOP_BITS(2)) u_dut2 (
    .i_Pclk(clk), .i_Rst_n(rst_n), .i_Rx(rx), .i_Parity(par),
    .o_Data(data2), .o_Enable(en2), .o_FrameErr(fe2), .o_Busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is the line bits placed by position: bit 0 start, 1..8 data,
  // 9 parity when present, then stop bits. pos: -1 idle, -2 waiting for high.
  logic [10:0] m_data[2];
  logic        m_en[2], m_fe[2], m_busy[2];
  int          pos[2];
  logic [10:0] fr[2];
  logic        hp[2], pe[2], pf[2];
  logic        d1, d2, mb;

  task automatic step(input int k, input logic b);
    int idx;
    int stopn;
    m_en[k] = pe[k];
    m_fe[k] = pf[k];
    pe[k] = 1'b0;
    pf[k] = 1'b0;
    if (pos[k] == -1) begin
      if (!b) begin
        pos[k] = 1;
        hp[k]  = ^par;
        fr[k]  = '0;
      end
    end else if (pos[k] == -2) begin
      if (b) pos[k] = -1;
    end else begin
      idx = pos[k];
      if (idx <= 8) begin
        fr[k][idx[3:0]] = b;
        pos[k]++;
      end else if (hp[k] && idx == 9) begin
        fr[k][9] = b;
        pos[k]++;
      end else begin
        stopn = idx - 9 - (hp[k] ? 1 : 0);
        if (!b) begin
          pf[k]  = 1'b1;
          pos[k] = -2;
        end else if (stopn == k) begin
          m_data[k] = fr[k];
          m_data[k][10] = 1'b1;
          pe[k]  = 1'b1;
          pos[k] = -1;
        end else begin
          pos[k]++;
        end
      end
    end
    m_busy[k] = (pos[k] != -1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = 1'b1;
      d2 = 1'b1;
      for (int k = 0; k < 2; k++) begin
        pos[k] = -1; fr[k] = '0; hp[k] = 1'b0; pe[k] = 1'b0; pf[k] = 1'b0;
        m_data[k] = '0; m_en[k] = 1'b0; m_fe[k] = 1'b0; m_busy[k] = 1'b0;
      end
    end else begin
      mb = (S == 2) ? d2 : rx;
      d2 = d1;
      d1 = rx;
      for (int k = 0; k < 2; k++) step(k, mb);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("data1", 32'(data1), 32'(m_data[0]));
      check("en1",   32'(en1),   32'(m_en[0]));
      check("fe1",   32'(fe1),   32'(m_fe[0]));
      check("busy1", 32'(busy1), 32'(m_busy[0]));
      check("data2", 32'(data2), 32'(m_data[1]));
      check("en2",   32'(en2),   32'(m_en[1]));
      check("fe2",   32'(fe2),   32'(m_fe[1]));
      check("busy2", 32'(busy2), 32'(m_busy[1]));
      if (en1) begin
        en_cyc.push_back(cyc);
        en_data.push_back(data1);
      end
      if (fe1) n_fe1++;
      if (en2) begin
        n_en2++;
        en2_last = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic b);
    @(negedge clk);
    rx = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  // cstop: edge number sampling the first stop bit
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic stopv,
                            input int nstop, input bit flip, output int cstop);
    logic pbit;
    cstop = 0;
    par = pm;
    drive(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (flip && i == 3) par = 2'b01;
      drive(d[i]);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      pbit = (pm == 2'b01) ? ^d : ~^d;
      drive(pbit);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(stopv);
      if (i == 0) cstop = cyc + 1;
    end
  endtask

  initial begin
    int cs, cs2, n0, fe0;

    // 1: reset with idle line
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(data1), 32'h000);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_en",   32'(en1),   32'h0);
    check("rst_fe",   32'(fe1),   32'h0);
    rst_n = 1'b1;
    idle(5);
    check("idle_no_en", 32'(en_cyc.size()), 32'd0);

    // 2: even parity 0xA5, two stop bits on the line so both instances complete
    n0 = en_cyc.size();
    send_frame(8'hA5, 2'b01, 1'b1, 2, 1'b0, cs);
    idle(6);
    check("t2_count", 32'(en_cyc.size()), 32'(n0 + 1));
    if (en_cyc.size() == n0 + 1) check("t2_latency", 32'(en_cyc[n0] - cs), 32'(1 + S));
    check("t2_data", 32'(data1), 32'h54A);
    check("t2_data_sb2", 32'(data2), 32'h54A);
    check("t2_count_sb2", 32'(n_en2), 32'd1);
    check("t2_latency_sb2", 32'(en2_last - (cs + 1)), 32'(1 + S));

    // 3: no parity 0x3C, parity input changed mid-frame
    n0 = en_cyc.size();
    send_frame(8'h3C, 2'b00, 1'b1, 1, 1'b1, cs);
    idle(6);
    check("t3_count", 32'(en_cyc.size()), 32'(n0 + 1));
    if (en_cyc.size() == n0 + 1) check("t3_latency", 32'(en_cyc[n0] - cs), 32'(1 + S));
    check("t3_data", 32'(data1), 32'h478);

    // 4: odd parity 0x01 with a bad stop bit, then a break, then a good frame
    n0 = en_cyc.size();
    fe0 = n_fe1;
    par = 2'b10;
    send_frame(8'h01, 2'b10, 1'b0, 1, 1'b0, cs);
    for (int i = 0; i < 20; i++) drive(1'b0);
    check("t4_fe_count", 32'(n_fe1), 32'(fe0 + 1));
    check("t4_no_en", 32'(en_cyc.size()), 32'(n0));
    check("t4_data_held", 32'(data1), 32'h478);
    check("t4_busy_break", 32'(busy1), 32'h1);
    idle(4);
    send_frame(8'h01, 2'b10, 1'b1, 1, 1'b0, cs);
    idle(6);
    check("t4_count", 32'(en_cyc.size()), 32'(n0 + 1));
    check("t4_data", 32'(data1), 32'h402);

    // 5: back-to-back even parity frames 0x55, 0xAA
    n0 = en_cyc.size();
    send_frame(8'h55, 2'b01, 1'b1, 1, 1'b0, cs);
    send_frame(8'hAA, 2'b01, 1'b1, 1, 1'b0, cs2);
    idle(8);
    check("t5_count", 32'(en_cyc.size()), 32'(n0 + 2));
    if (en_cyc.size() == n0 + 2) begin
      check("t5_gap", 32'(en_cyc[n0 + 1] - en_cyc[n0]), 32'd11);
      check("t5_data_a", 32'(en_data[n0]), 32'h4AA);
      check("t5_data_b", 32'(en_data[n0 + 1]), 32'h554);
    end
    check("t5_data", 32'(data1), 32'h554);

    // 6: reset in the middle of DATA for 0xFF
    n0 = en_cyc.size();
    par = 2'b01;
    drive(1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1);
    repeat (S + 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data", 32'(data1), 32'h000);
    check("t6_rst_busy", 32'(busy1), 32'h0);
    check("t6_rst_en",   32'(en1),   32'h0);
    check("t6_rst_data2", 32'(data2), 32'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx = 1'b1;
    idle(4);
    check("t6_no_en", 32'(en_cyc.size()), 32'(n0));
    send_frame(8'hA5, 2'b01, 1'b1, 2, 1'b0, cs);
    idle(6);
    check("t6_count", 32'(en_cyc.size()), 32'(n0 + 1));
    check("t6_data", 32'(data1), 32'h54A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop guard in case stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
